// File: rtl/vx_afu_wr_fence.sv
// Per-bank AXI write-burst tracker with AW throttling and a drain fence handshake.
// Optional drain watchdog enabled by defining AFU_WR_FENCE_TIMEOUT_EN.
`timescale 1ns/1ps

module vx_afu_wr_fence #(
  parameter int NUM_BANKS      = 1,
  parameter int MAX_PENDING    = 256,
  parameter int TOTALW         = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BANKS-1:0] in_awvalid,
  output logic [NUM_BANKS-1:0] in_awready,
  output logic [NUM_BANKS-1:0] out_awvalid,
  input  logic [NUM_BANKS-1:0] out_awready,
  input  logic [NUM_BANKS-1:0] bvalid,
  input  logic [NUM_BANKS-1:0] bready,
  input  logic                 fence_req,
  output logic                 fence_ack,
  output logic [TOTALW-1:0]    pending_total,
  output logic                 wr_idle,
  output logic                 underflow_err,
  output logic                 fence_timeout
);

  localparam int CNTW = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNTW-1:0]       pending     [NUM_BANKS];
  logic [CNTW-1:0]       pending_nxt [NUM_BANKS];
  logic [NUM_BANKS-1:0]  block, aw_fire, b_fire, uflow;
  logic [TOTALW-1:0]     total_nxt;
  logic                  all_zero_nxt;

  // AW gating and per-bank counter next values; everything here is zero-latency.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    all_zero_nxt = 1'b1;
    total_nxt    = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      block[i]       = fence_req | (state != IDLE) | (pending[i] == CNTW'(MAX_PENDING));
      out_awvalid[i] = in_awvalid[i] & ~block[i];
      in_awready[i]  = out_awready[i] & ~block[i];
      aw_fire[i]     = out_awvalid[i] & out_awready[i];
      b_fire[i]      = bvalid[i] & bready[i];
      pending_nxt[i] = pending[i];
      uflow[i]       = 1'b0;
      case ({aw_fire[i], b_fire[i]})
        2'b10: pending_nxt[i] = pending[i] + CNTW'(1);
        2'b01: begin
          if (pending[i] != '0) pending_nxt[i] = pending[i] - CNTW'(1);
          else                  uflow[i]       = 1'b1;
        end
        default: pending_nxt[i] = pending[i];
      endcase
      if (pending_nxt[i] != '0) all_zero_nxt = 1'b0;
      total_nxt = total_nxt + TOTALW'(pending_nxt[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the counter array is tiny and must be clean for the fence, so each entry is reset explicitly.
      for (int i = 0; i < NUM_BANKS; i++) pending[i] <= '0;
      pending_total <= '0;
      wr_idle       <= 1'b1;
      underflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) pending[i] <= pending_nxt[i];
      pending_total <= total_nxt;
      wr_idle       <= all_zero_nxt;
      if (|uflow) underflow_err <= 1'b1;
    end
  end

  // Fence FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Fence FSM: next state. Drain completion looks at post-update counters.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fence_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!fence_req)        state_nxt = IDLE;
        else if (all_zero_nxt) state_nxt = DONE;
      end
      DONE:    if (!fence_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fence FSM: outputs.
  always_comb begin
    fence_ack = (state == DONE);
  end

`ifdef AFU_WR_FENCE_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TOW-1:0] to_cnt;
  logic           to_flag;

  // Watchdog only reports; the FSM keeps waiting in DRAIN regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state != DRAIN && state_nxt == DRAIN) begin
      to_cnt <= '0;
    end else if (state == DRAIN && to_cnt != TOW'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + TOW'(1);
      if (to_cnt == TOW'(TIMEOUT_CYCLES - 1)) to_flag <= 1'b1;
    end
  end

  assign fence_timeout = to_flag;
`else
  assign fence_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vx_afu_wr_fence.sv
// Self-checking bench for vx_afu_wr_fence: directed scenarios plus randomized
// traffic against a per-bank outstanding-count reference model.
`timescale 1ns/1ps

module tb_vx_afu_wr_fence;

  localparam int NB   = 2;
  localparam int MAXP = 6;
  localparam int TW   = 12;
  localparam int TO   = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] in_awvalid, in_awready, out_awvalid, out_awready, bvalid, bready;
  logic          fence_req, fence_ack, wr_idle, underflow_err, fence_timeout;
  logic [TW-1:0] pending_total;

  int checks   = 0;
  int failures = 0;

  vx_afu_wr_fence #(
    .NUM_BANKS(NB), .MAX_PENDING(MAXP), .TOTALW(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_awvalid(in_awvalid), .in_awready(in_awready),
    .out_awvalid(out_awvalid), .out_awready(out_awready),
    .bvalid(bvalid), .bready(bready),
    .fence_req(fence_req), .fence_ack(fence_ack),
    .pending_total(pending_total), .wr_idle(wr_idle),
    .underflow_err(underflow_err), .fence_timeout(fence_timeout)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of AW (valid+ready) and B (valid+ready) activity on the given banks.
  task automatic fire(input logic [NB-1:0] aw, input logic [NB-1:0] b);
    in_awvalid = aw; out_awready = aw; bvalid = b; bready = b;
    step();
    in_awvalid = '0; out_awready = '0; bvalid = '0; bready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; fence_req = 1'b0;
    in_awvalid = '0; out_awready = '0; bvalid = '0; bready = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pending_total !== 12'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", pending_total); end
    checks++; if (wr_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", wr_idle); end
    checks++; if (fence_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", fence_ack); end
    checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL reset_uflow got=%b exp=0", underflow_err); end
    checks++; if (fence_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", fence_timeout); end
    in_awvalid = 2'b11; out_awready = 2'b11; #1;
    checks++; if (out_awvalid !== 2'b11 || in_awready !== 2'b11)
      begin failures++; $display("FAIL reset_pass got=%b/%b exp=11/11", out_awvalid, in_awready); end
    in_awvalid = '0; out_awready = '0;
  endtask

  task automatic test_count();
    for (int k = 0; k < 4; k++) begin
      fire((k < 3) ? 2'b01 : 2'b10, 2'b00);
      checks++; if (pending_total !== TW'(k + 1))
        begin failures++; $display("FAIL count_up%0d got=%0d exp=%0d", k, pending_total, k + 1); end
    end
    checks++; if (wr_idle !== 1'b0) begin failures++; $display("FAIL count_busy got=%b exp=0", wr_idle); end
    for (int k = 0; k < 4; k++) begin
      fire(2'b00, (k < 3) ? 2'b01 : 2'b10);
      checks++; if (pending_total !== TW'(3 - k))
        begin failures++; $display("FAIL count_dn%0d got=%0d exp=%0d", k, pending_total, 3 - k); end
      checks++; if (wr_idle !== (k == 3))
        begin failures++; $display("FAIL count_idle%0d got=%b exp=%b", k, wr_idle, k == 3); end
    end
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 5; k++) fire(2'b01, 2'b00);
    fire(2'b01, 2'b01);
    checks++; if (pending_total !== 12'd5) begin failures++; $display("FAIL same_total got=%0d exp=5", pending_total); end
    checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL same_uflow got=%b exp=0", underflow_err); end
    for (int k = 0; k < 5; k++) fire(2'b00, 2'b01);
    checks++; if (pending_total !== 12'd0) begin failures++; $display("FAIL same_drain got=%0d exp=0", pending_total); end
  endtask

  task automatic test_cap();
    int n;
    in_awvalid = 2'b01; out_awready = 2'b01;
    n = 0;
    for (int k = 0; k < MAXP + 3; k++) begin
      #1; if (out_awvalid[0] && out_awready[0]) n++;
      step();
    end
    checks++; if (n !== MAXP) begin failures++; $display("FAIL cap_fires got=%0d exp=%0d", n, MAXP); end
    #1;
    checks++; if (out_awvalid[0] !== 1'b0 || in_awready[0] !== 1'b0)
      begin failures++; $display("FAIL cap_block got=%b/%b exp=0/0", out_awvalid[0], in_awready[0]); end
    bvalid = 2'b01; bready = 2'b01;
    step();
    bvalid = '0; bready = '0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      #1; if (out_awvalid[0] && out_awready[0]) n++;
      step();
    end
    checks++; if (n !== 1) begin failures++; $display("FAIL cap_refill got=%0d exp=1", n); end
    checks++; if (pending_total !== TW'(MAXP)) begin failures++; $display("FAIL cap_total got=%0d exp=%0d", pending_total, MAXP); end
    in_awvalid = '0; out_awready = '0;
    for (int k = 0; k < MAXP; k++) fire(2'b00, 2'b01);
  endtask

  task automatic test_fence();
    fire(2'b01, 2'b00); fire(2'b01, 2'b00); fire(2'b10, 2'b00);
    fence_req = 1'b1; in_awvalid = 2'b11; out_awready = 2'b11; #1;
    checks++; if (out_awvalid !== 2'b00 || in_awready !== 2'b00)
      begin failures++; $display("FAIL fence_block got=%b/%b exp=00/00", out_awvalid, in_awready); end
    step();
    for (int k = 0; k < 3; k++) begin
      bvalid = (k < 2) ? 2'b01 : 2'b10; bready = bvalid;
      step();
      checks++; if (fence_ack !== (k == 2))
        begin failures++; $display("FAIL fence_ack%0d got=%b exp=%b", k, fence_ack, k == 2); end
    end
    bvalid = '0; bready = '0;
    checks++; if (pending_total !== 12'd0) begin failures++; $display("FAIL fence_total got=%0d exp=0", pending_total); end
    out_awready = 2'b00; fence_req = 1'b0; #1;
    checks++; if (out_awvalid !== 2'b00) begin failures++; $display("FAIL fence_done_block got=%b exp=00", out_awvalid); end
    step();
    checks++; if (fence_ack !== 1'b0) begin failures++; $display("FAIL fence_release_ack got=%b exp=0", fence_ack); end
    checks++; if (out_awvalid !== 2'b11) begin failures++; $display("FAIL fence_unblock got=%b exp=11", out_awvalid); end
    in_awvalid = '0;
    // Request withdrawn during drain: no acknowledge.
    fire(2'b01, 2'b00);
    fence_req = 1'b1; step();
    fence_req = 1'b0; step(); step();
    checks++; if (fence_ack !== 1'b0) begin failures++; $display("FAIL fence_abort_ack got=%b exp=0", fence_ack); end
    fire(2'b00, 2'b01);
    // Request while already drained: ack two cycles later.
    fence_req = 1'b1; step();
    checks++; if (fence_ack !== 1'b0) begin failures++; $display("FAIL fence_idle_ack1 got=%b exp=0", fence_ack); end
    step();
    checks++; if (fence_ack !== 1'b1) begin failures++; $display("FAIL fence_idle_ack2 got=%b exp=1", fence_ack); end
    fence_req = 1'b0; step();
    checks++; if (fence_ack !== 1'b0) begin failures++; $display("FAIL fence_idle_drop got=%b exp=0", fence_ack); end
  endtask

  task automatic test_timeout();
    logic exp_to;
`ifdef AFU_WR_FENCE_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    fire(2'b01, 2'b00);
    fence_req = 1'b1; step();
    for (int k = 0; k < TO - 1; k++) step();
    checks++; if (fence_timeout !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", fence_timeout); end
    step();
    checks++; if (fence_timeout !== exp_to) begin failures++; $display("FAIL timeout_set got=%b exp=%b", fence_timeout, exp_to); end
    checks++; if (fence_ack !== 1'b0) begin failures++; $display("FAIL timeout_noack got=%b exp=0", fence_ack); end
    fire(2'b00, 2'b01);
    checks++; if (fence_ack !== 1'b1 || fence_timeout !== exp_to)
      begin failures++; $display("FAIL timeout_ack got=%b/%b exp=1/%b", fence_ack, fence_timeout, exp_to); end
    fence_req = 1'b0; step();
  endtask

  task automatic test_underflow();
    fire(2'b00, 2'b01);
    checks++; if (pending_total !== 12'd0 || underflow_err !== 1'b1)
      begin failures++; $display("FAIL uflow_set got=%0d/%b exp=0/1", pending_total, underflow_err); end
    step(); step(); step();
    checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL uflow_sticky got=%b exp=1", underflow_err); end
    for (int k = 0; k < 3; k++) fire(2'b01, 2'b00);
    fence_req = 1'b1; step(); step();
    reset = 1'b1; fence_req = 1'b0; step();
    reset = 1'b0;
    checks++; if (pending_total !== 12'd0 || wr_idle !== 1'b1 || fence_ack !== 1'b0 ||
                  underflow_err !== 1'b0 || fence_timeout !== 1'b0)
      begin failures++; $display("FAIL uflow_reset got=%0d/%b/%b/%b/%b exp=0/1/0/0/0",
        pending_total, wr_idle, fence_ack, underflow_err, fence_timeout); end
    in_awvalid = 2'b11; #1;
    checks++; if (out_awvalid !== 2'b11) begin failures++; $display("FAIL uflow_unblock got=%b exp=11", out_awvalid); end
    in_awvalid = '0;
    fire(2'b00, 2'b01);
    checks++; if (underflow_err !== 1'b1 || pending_total !== 12'd0)
      begin failures++; $display("FAIL uflow_late got=%b/%0d exp=1/0", underflow_err, pending_total); end
  endtask

  // Random traffic, no fence: model keeps outstanding counts per bank.
  task automatic test_random();
    int pend [NB];
    logic uf;
    logic [NB-1:0] exp_v, exp_r;
    int sum;
    do_reset();
    for (int b = 0; b < NB; b++) pend[b] = 0;
    uf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_awvalid  = NB'($urandom);
      out_awready = NB'($urandom);
      for (int b = 0; b < NB; b++) begin
        bvalid[b] = ($urandom_range(0, 2) == 0);
        bready[b] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int b = 0; b < NB; b++) begin
        exp_v[b] = in_awvalid[b] && pend[b] < MAXP;
        exp_r[b] = out_awready[b] && pend[b] < MAXP;
      end
      checks++; if (out_awvalid !== exp_v || in_awready !== exp_r)
        begin failures++; $display("FAIL rand_gate c=%0d got=%b/%b exp=%b/%b", c, out_awvalid, in_awready, exp_v, exp_r); end
      for (int b = 0; b < NB; b++) begin
        if (exp_v[b] && out_awready[b] && !(bvalid[b] && bready[b])) pend[b]++;
        else if (!(exp_v[b] && out_awready[b]) && bvalid[b] && bready[b]) begin
          if (pend[b] > 0) pend[b]--;
          else uf = 1'b1;
        end
      end
      step();
      sum = 0;
      for (int b = 0; b < NB; b++) sum += pend[b];
      checks++; if (pending_total !== TW'(sum) || wr_idle !== (sum == 0) || underflow_err !== uf)
        begin failures++; $display("FAIL rand_state c=%0d got=%0d/%b/%b exp=%0d/%b/%b",
          c, pending_total, wr_idle, underflow_err, sum, sum == 0, uf); end
    end
    in_awvalid = '0; out_awready = '0; bvalid = '0; bready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_same_cycle();
    test_cap();
    test_fence();
    test_timeout();
    test_underflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
